// File: rtl/bram_stream_reader.sv
// Streams LEN consecutive words out of a pipelined block RAM as a valid/ready stream.
// Reads are issued only when a FIFO slot is reserved for them, so the buffer cannot overflow.
module bram_stream_reader #(
    parameter int unsigned RAM_WIDTH    = 18,
    parameter int unsigned RAM_DEPTH    = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned ADDR_W      = $clog2(RAM_DEPTH - 1)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W:0]      len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_en,
    output logic                 mem_regce,
    input  logic [RAM_WIDTH-1:0] mem_dout,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W:0]         remain_q;
    logic                    done_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] lst_q;
    logic [RAM_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
    logic                    fifo_lst [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W:0]          count_q;

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        credit;
    logic                    issue;
    logic                    last_issue;
    logic                    wr_en;
    logic                    rd_en;
    logic [ADDR_W-1:0]       addr_next;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
    end

    // Reads in flight and words already buffered both hold a FIFO slot.
    assign credit     = inflight + CNT_W'(count_q);
    assign issue      = (state_q == StRun) && (remain_q != '0) && (credit < CNT_W'(FIFO_DEPTH));
    assign last_issue = issue && (remain_q == (ADDR_W + 1)'(1));
    assign addr_next  = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

    assign wr_en   = vld_q[READ_LATENCY-1];
    assign m_valid = (count_q != '0);
    assign rd_en   = m_valid && m_ready;
    assign m_data  = m_valid ? fifo_mem[rd_ptr_q] : '0;
    assign m_last  = m_valid && fifo_lst[rd_ptr_q];

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_en    = issue;
    assign mem_regce = busy;

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_q   <= start_addr;
                            remain_q <= len;
                            state_q  <= StRun;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        addr_q   <= addr_next;
                        remain_q <= remain_q - 1'b1;
                        if (last_issue) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (rd_en && m_last) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag pipeline mirrors the RAM read latency; reset drops any reads still in flight.
    always_ff @(posedge clka) begin
        if (rstb) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= issue;
            lst_q[0] <= last_issue;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= mem_dout;
            fifo_lst[wr_ptr_q] <= lst_q[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a 2-cycle pipelined RAM model holding RAM[i]=i.
module tb_bram_stream_reader;

    localparam int unsigned RAM_WIDTH = 18;
    localparam int unsigned RAM_DEPTH = 1024;
    localparam int unsigned ADDR_W    = 10;

    logic                 clka = 1'b0;
    logic                 rstb = 1'b1;
    logic                 start = 1'b0;
    logic [ADDR_W-1:0]    start_addr = '0;
    logic [ADDR_W:0]      len = '0;
    logic                 busy, done, mem_en, mem_regce, m_valid, m_last;
    logic                 m_ready = 1'b0;
    logic [ADDR_W-1:0]    mem_addr;
    logic [RAM_WIDTH-1:0] mem_dout = '0;
    logic [RAM_WIDTH-1:0] m_data;

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_r1 = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] en_mask, vld_mask, last_mask, done_mask, busy_mask;
    int          en_cnt, en_at20, done_cnt, stall_bad;
    int          words[$];
    int          addrs[$];

    bram_stream_reader #(
        .RAM_WIDTH(RAM_WIDTH),
        .RAM_DEPTH(RAM_DEPTH),
        .READ_LATENCY(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clka(clka),
        .rstb(rstb),
        .start(start),
        .start_addr(start_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .mem_addr(mem_addr),
        .mem_en(mem_en),
        .mem_regce(mem_regce),
        .mem_dout(mem_dout),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_ready(m_ready)
    );

    always #5 clka = ~clka;

    // HIGH_PERFORMANCE RAM: array read on en, output register loaded on regce.
    always @(posedge clka) begin
        if (mem_en) ram_r1 <= ram[mem_addr];
        if (mem_regce) mem_dout <= ram_r1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_ctl"}, {26'd0, busy, done, mem_en, mem_regce, m_valid, m_last}, 32'd0);
        chk_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk_eq({tag, "_data"}, 32'(m_data), 32'd0);
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // mode 0: ready high; 1: ready low for 20 cycles; 2: ready toggles 1,0,...;
    // 3: ready high plus a second start while busy; 4: ready low, reset in cycle 3.
    task automatic xfer(input int sa, input int n, input int mode, input int win);
        logic                 prev_stall;
        logic [RAM_WIDTH-1:0] prev_data;
        logic                 prev_last;
        en_mask = '0; vld_mask = '0; last_mask = '0; done_mask = '0; busy_mask = '0;
        en_cnt = 0; en_at20 = 0; done_cnt = 0; stall_bad = 0;
        words.delete();
        addrs.delete();
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        len        = (ADDR_W + 1)'(n);
        for (int c = 0; c < win; c++) begin
            if (c == 1) start = 1'b0;
            case (mode)
                1:       m_ready = (c >= 20);
                2:       m_ready = (c % 2 == 0);
                4:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
            if (mode == 3 && c == 2) begin
                start = 1'b1; start_addr = ADDR_W'(300); len = (ADDR_W + 1)'(2);
            end
            if (mode == 3 && c == 3) start = 1'b0;
            if (mode == 4 && c == 3) rstb = 1'b1;
            if (mode == 4 && c == 4) rstb = 1'b0;
            #1;
            if (mode == 4 && c == 4) chk_zero("t6_reset_outputs");
            if (c < 32) begin
                en_mask[c]   = mem_en;
                vld_mask[c]  = m_valid;
                last_mask[c] = m_valid && m_last;
                done_mask[c] = done;
                busy_mask[c] = busy;
            end
            if (mem_en) begin
                en_cnt++;
                if (c < 20) en_at20++;
                addrs.push_back(int'(mem_addr));
            end
            if (done) done_cnt++;
            if (prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last))
                stall_bad++;
            if (m_valid && m_ready) words.push_back(int'(m_data));
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            step();
        end
    endtask

    task automatic chk_words(input string tag, input int base, input int n);
        chk_eq({tag, "_count"}, 32'(words.size()), 32'(n));
        for (int i = 0; i < n && i < words.size(); i++)
            chk_eq($sformatf("%s_w%0d", tag, i), 32'(words[i]), 32'((base + i) % RAM_DEPTH));
    endtask

    initial begin
        for (int i = 0; i < int'(RAM_DEPTH); i++) ram[i] = RAM_WIDTH'(i);
        rstb = 1'b1;
        repeat (3) step();
        rstb = 1'b0;
        step();
        chk_zero("reset");

        // 1: basic timing
        xfer(5, 4, 0, 12);
        chk_eq("t1_en_cycles", en_mask, 32'h0000_001E);
        chk_eq("t1_valid_cycles", vld_mask, 32'h0000_00F0);
        chk_eq("t1_last_cycle", last_mask, 32'h0000_0080);
        chk_eq("t1_done_cycle", done_mask, 32'h0000_0100);
        chk_words("t1", 5, 4);

        // 2: address wrap
        xfer(1022, 4, 0, 12);
        chk_eq("t2_addr_count", 32'(addrs.size()), 32'd4);
        chk_eq("t2_addr0", 32'(addrs.size() > 0 ? addrs[0] : -1), 32'd1022);
        chk_eq("t2_addr1", 32'(addrs.size() > 1 ? addrs[1] : -1), 32'd1023);
        chk_eq("t2_addr2", 32'(addrs.size() > 2 ? addrs[2] : -1), 32'd0);
        chk_eq("t2_addr3", 32'(addrs.size() > 3 ? addrs[3] : -1), 32'd1);
        chk_words("t2", 1022, 4);

        // 3: long backpressure
        xfer(100, 16, 1, 60);
        chk_eq("t3_reads_while_stalled", 32'(en_at20), 32'd4);
        chk_eq("t3_reads_total", 32'(en_cnt), 32'd16);
        chk_eq("t3_done_count", 32'(done_cnt), 32'd1);
        chk_eq("t3_stall_stable", 32'(stall_bad), 32'd0);
        chk_words("t3", 100, 16);

        // 4: toggling ready
        xfer(200, 8, 2, 30);
        chk_eq("t4_done_count", 32'(done_cnt), 32'd1);
        chk_eq("t4_stall_stable", 32'(stall_bad), 32'd0);
        chk_words("t4", 200, 8);

        // 5: zero length, then start while busy
        xfer(50, 0, 0, 6);
        chk_eq("t5_len0_done", done_mask, 32'h0000_0002);
        chk_eq("t5_len0_reads", 32'(en_cnt), 32'd0);
        chk_eq("t5_len0_busy", busy_mask, 32'd0);
        xfer(5, 4, 3, 14);
        chk_eq("t5_busy_start_en", en_mask, 32'h0000_001E);
        chk_eq("t5_busy_start_done", done_mask, 32'h0000_0100);
        chk_words("t5", 5, 4);

        // 6: reset mid-transfer, then fresh transfer
        xfer(40, 8, 4, 12);
        chk_eq("t6_no_done", 32'(done_cnt), 32'd0);
        chk_eq("t6_reads_before_reset", 32'(en_cnt), 32'd3);
        xfer(600, 3, 0, 12);
        chk_eq("t6_fresh_done", 32'(done_cnt), 32'd1);
        chk_words("t6", 600, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
